// File: rtl/game_pkg.sv
// Shared definitions for the memory-game datapath: colour codes, default
// LFSR seed, player FSM states and the sequence LFSR step function.
package game_pkg;

  localparam logic [1:0] COL_RED    = 2'd0;
  localparam logic [1:0] COL_BLUE   = 2'd1;
  localparam logic [1:0] COL_YELLOW = 2'd2;
  localparam logic [1:0] COL_GREEN  = 2'd3;

  // A zero seed would lock the LFSR, so it is replaced by this value.
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    PS_IDLE,
    PS_LOAD,
    PS_SHOW,
    PS_GAP,
    PS_DONE
  } player_state_e;

  // One Fibonacci step, taps 16/14/13/11.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/game_lfsr16.sv
// 16-bit sequence LFSR shared by the player and the input checker so that
// replay and check stay bit-identical. Load has priority over advance.
module game_lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        advance,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  // Select the next LFSR value: reload, step, or hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (advance) begin
      q_d = lfsr16_next(q_q);
    end
  end

  // LFSR state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sequence_player.sv
// Replays a seeded pseudo-random colour sequence, one step at a time: each
// step shows a colour with colour_valid for ON_CYCLES, then a blank gap.
module sequence_player
  import game_pkg::*;
#(
  parameter int LFSR_W     = 16,
  parameter int LEN_W      = 5,
  parameter int ON_CYCLES  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LEN_W-1:0]  len,
  output logic [1:0]        colour,
  output logic              colour_valid,
  output logic [LEN_W-1:0]  step,
  output logic              busy,
  output logic              done
);

  localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  player_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  step_q, step_d;
  logic [1:0]        colour_q, colour_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt, seed_eff;
  logic              accept, last_step, lfsr_load, lfsr_adv;
  logic              unused_lfsr_bits;

  assign accept    = (state_q == PS_IDLE) && start && !abort;
  assign last_step = (step_q == len_q - LEN_W'(1));
  assign lfsr_load = accept && (len != '0);
  assign lfsr_adv  = !abort && (state_q == PS_GAP) && (cnt_q == '0) && !last_step;
  assign seed_eff  = (seed == '0) ? LFSR_DEFAULT_SEED : seed;
  assign lfsr_nxt  = lfsr16_next(lfsr_q);
  assign unused_lfsr_bits = ^lfsr_nxt[LFSR_W-1:2];

  game_lfsr16 u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (seed_eff),
    .advance  (lfsr_adv),
    .q        (lfsr_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort beats everything, including a start in IDLE.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = PS_IDLE;
    end else begin
      case (state_q)
        PS_IDLE: if (start) state_d = (len == '0) ? PS_DONE : PS_LOAD;
        PS_LOAD: state_d = PS_SHOW;
        PS_SHOW: if (cnt_q == '0) state_d = PS_GAP;
        PS_GAP:  if (cnt_q == '0) state_d = last_step ? PS_DONE : PS_SHOW;
        PS_DONE: state_d = PS_IDLE;
        default: state_d = PS_IDLE;
      endcase
    end
  end

  // Output and datapath next values; flags follow the state being entered.
  always_comb begin
    len_d    = len_q;
    step_d   = step_q;
    colour_d = colour_q;
    cnt_d    = cnt_q;
    if (lfsr_load) begin
      len_d  = len;
      step_d = '0;
    end
    if (!abort && (state_q == PS_LOAD)) begin
      colour_d = lfsr_q[1:0];
    end
    if (lfsr_adv) begin
      step_d   = step_q + LEN_W'(1);
      colour_d = lfsr_nxt[1:0];
    end
    // The on/gap counter reloads on every state entry and counts down to 0.
    if (state_d != state_q) begin
      case (state_d)
        PS_SHOW: cnt_d = ON_LAST;
        PS_GAP:  cnt_d = GAP_LAST;
        default: cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    valid_d = (state_d == PS_SHOW);
    busy_d  = (state_d == PS_LOAD) || (state_d == PS_SHOW) || (state_d == PS_GAP);
    done_d  = (state_d == PS_DONE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      len_q    <= '0;
      step_q   <= '0;
      colour_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      step_q   <= step_d;
      colour_q <= colour_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign colour       = colour_q;
  assign colour_valid = valid_q;
  assign step         = step_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: records every cycle of a playback and checks it
// against a cycle-numbered model derived from the seed, length and timing.
module tb_sequence_player;

  localparam int ON  = 4;
  localparam int GAP = 2;
  localparam int P   = ON + GAP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] seed = '0;
  logic [4:0]  len = '0;
  logic [1:0]  colour;
  logic        colour_valid;
  logic [4:0]  step;
  logic        busy;
  logic        done;

  sequence_player #(
    .LFSR_W(16), .LEN_W(5), .ON_CYCLES(ON), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed), .len(len),
    .colour(colour), .colour_valid(colour_valid), .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic       obs_v [0:255];
  logic       obs_b [0:255];
  logic       obs_d [0:255];
  logic [1:0] obs_c [0:255];
  logic [4:0] obs_s [0:255];

  logic [1:0] colq[$];
  logic       e_v, e_b, e_d, e_cs;
  logic [1:0] e_c;
  int         e_s;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Colour list of a sequence: each step is the low two bits of the shift register.
  function automatic void build_colq(input logic [15:0] sd, input int n);
    int s;
    colq.delete();
    s = (sd == 16'h0) ? 32'hACE1 : int'(sd);
    for (int k = 0; k < n; k++) begin
      colq.push_back(2'(s % 4));
      s = ((s * 2) % 65536) | (((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1);
    end
  endfunction

  // Expected outputs in cycle c after a start in cycle 0 (ab = abort cycle or -1).
  function automatic void model(input int c, input int n, input int ab);
    int cc;
    int k;
    e_v = 1'b0; e_b = 1'b0; e_d = 1'b0; e_cs = 1'b0; e_c = 2'd0; e_s = 0;
    cc = (ab >= 0 && c > ab) ? ab : c;
    if (n == 0) begin
      e_d = (c == 1);
      return;
    end
    if (cc >= 2) begin
      k = (cc - 2) / P;
      if (k > n - 1) k = n - 1;
      e_cs = 1'b1;
      e_s  = k;
      e_c  = colq[k];
    end
    if (ab >= 0 && c > ab) return;
    e_b = (c >= 1) && (c <= n * P + 1);
    e_d = (c == n * P + 2);
    e_v = (c >= 2) && (c <= n * P + 1) && (((c - 2) % P) < ON);
  endfunction

  // Start a playback in cycle 0 and record cycles 0..ncyc.
  task automatic run_seq(input logic [15:0] sd, input int n, input int ab, input int rs,
                         input bit noise, input int ncyc);
    seed = sd; len = 5'(n); start = 1'b1; abort = 1'b0;
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      obs_v[c] = colour_valid; obs_b[c] = busy; obs_d[c] = done;
      obs_c[c] = colour; obs_s[c] = step;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = (c + 1 == ab);
      rst_n = !(c + 1 == rs);
      if (noise && (c + 1 <= n * P + 1)) begin
        start = 1'($urandom);
        seed  = 16'($urandom);
        len   = 5'($urandom);
      end
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({colour, colour_valid, step, busy, done} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_state got col%0d v%b step%0d b%b d%b want all zero",
               colour, colour_valid, step, busy, done);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    build_colq(16'h0003, 3);
    run_seq(16'h0003, 3, -1, 9, 1'b0, 14);
    for (int c = 0; c <= 14; c++) begin
      if (c <= 9) model(c, 3, -1);
      else begin e_v = 0; e_b = 0; e_d = 0; e_cs = 1; e_c = 0; e_s = 0; end
      n_cmp++;
      if (obs_v[c] !== e_v || obs_b[c] !== e_b || obs_d[c] !== e_d ||
          (e_cs && (obs_c[c] !== e_c || obs_s[c] !== 5'(e_s)))) begin
        n_bad++;
        $display("FAIL mid_reset c=%0d got v%b b%b d%b col%0d step%0d want v%b b%b d%b col%0d step%0d",
                 c, obs_v[c], obs_b[c], obs_d[c], obs_c[c], obs_s[c], e_v, e_b, e_d, e_c, e_s);
      end
    end
  endtask

  task automatic test_fixed_seed;
    build_colq(16'h0003, 3);
    run_seq(16'h0003, 3, -1, -1, 1'b0, 22);
    for (int c = 0; c <= 22; c++) begin
      model(c, 3, -1);
      n_cmp++;
      if (obs_v[c] !== e_v || obs_b[c] !== e_b || obs_d[c] !== e_d ||
          (e_cs && (obs_c[c] !== e_c || obs_s[c] !== 5'(e_s)))) begin
        n_bad++;
        $display("FAIL seed3 c=%0d got v%b b%b d%b col%0d step%0d want v%b b%b d%b col%0d step%0d",
                 c, obs_v[c], obs_b[c], obs_d[c], obs_c[c], obs_s[c], e_v, e_b, e_d, e_c, e_s);
      end
    end
    n_cmp++;
    if (obs_c[2] !== 2'd3 || obs_c[8] !== 2'd2 || obs_c[14] !== 2'd0 || obs_d[20] !== 1'b1) begin
      n_bad++;
      $display("FAIL seed3_const got col %0d/%0d/%0d done20=%b want 3/2/0 done20=1",
               obs_c[2], obs_c[8], obs_c[14], obs_d[20]);
    end
  endtask

  task automatic test_zero_seed;
    build_colq(16'h0000, 1);
    run_seq(16'h0000, 1, -1, -1, 1'b0, 10);
    for (int c = 0; c <= 10; c++) begin
      model(c, 1, -1);
      n_cmp++;
      if (obs_v[c] !== e_v || obs_b[c] !== e_b || obs_d[c] !== e_d ||
          (e_cs && (obs_c[c] !== e_c || obs_s[c] !== 5'(e_s)))) begin
        n_bad++;
        $display("FAIL seed0 c=%0d got v%b b%b d%b col%0d step%0d want v%b b%b d%b col%0d step%0d",
                 c, obs_v[c], obs_b[c], obs_d[c], obs_c[c], obs_s[c], e_v, e_b, e_d, e_c, e_s);
      end
    end
    n_cmp++;
    if (obs_c[3] !== 2'd1 || obs_d[8] !== 1'b1) begin
      n_bad++;
      $display("FAIL seed0_const got col%0d done8=%b want col1 done8=1", obs_c[3], obs_d[8]);
    end
  endtask

  task automatic test_prefix;
    logic [15:0] sd;
    int nv;
    sd = 16'($urandom);
    for (int n = 5; n <= 6; n++) begin
      build_colq(sd, n);
      run_seq(sd, n, -1, -1, 1'b0, n * P + 4);
      nv = 0;
      for (int c = 0; c <= n * P + 4; c++) begin
        model(c, n, -1);
        if (obs_v[c] === 1'b1) nv++;
        n_cmp++;
        if (obs_v[c] !== e_v || obs_b[c] !== e_b || obs_d[c] !== e_d ||
            (e_cs && (obs_c[c] !== e_c || obs_s[c] !== 5'(e_s)))) begin
          n_bad++;
          $display("FAIL prefix len%0d c=%0d got v%b b%b d%b col%0d step%0d want v%b b%b d%b col%0d step%0d",
                   n, c, obs_v[c], obs_b[c], obs_d[c], obs_c[c], obs_s[c], e_v, e_b, e_d, e_c, e_s);
        end
      end
      n_cmp++;
      if (nv != n * ON) begin
        n_bad++;
        $display("FAIL prefix_count len%0d got %0d valid cycles want %0d", n, nv, n * ON);
      end
    end
  endtask

  task automatic test_len_zero;
    build_colq(16'h1234, 0);
    run_seq(16'h1234, 0, -1, -1, 1'b0, 5);
    for (int c = 0; c <= 5; c++) begin
      model(c, 0, -1);
      n_cmp++;
      if (obs_v[c] !== e_v || obs_b[c] !== e_b || obs_d[c] !== e_d) begin
        n_bad++;
        $display("FAIL len0 c=%0d got v%b b%b d%b want v%b b%b d%b",
                 c, obs_v[c], obs_b[c], obs_d[c], e_v, e_b, e_d);
      end
    end
  endtask

  task automatic test_abort_and_ignore;
    logic [15:0] sd;
    sd = 16'($urandom);
    build_colq(sd, 3);
    run_seq(sd, 3, 9, -1, 1'b0, 22);
    for (int c = 0; c <= 22; c++) begin
      model(c, 3, 9);
      n_cmp++;
      if (obs_v[c] !== e_v || obs_b[c] !== e_b || obs_d[c] !== e_d ||
          (e_cs && (obs_c[c] !== e_c || obs_s[c] !== 5'(e_s)))) begin
        n_bad++;
        $display("FAIL abort c=%0d got v%b b%b d%b col%0d step%0d want v%b b%b d%b col%0d step%0d",
                 c, obs_v[c], obs_b[c], obs_d[c], obs_c[c], obs_s[c], e_v, e_b, e_d, e_c, e_s);
      end
    end
    build_colq(16'h0003, 3);
    run_seq(16'h0003, 3, -1, -1, 1'b1, 22);
    for (int c = 0; c <= 22; c++) begin
      model(c, 3, -1);
      n_cmp++;
      if (obs_v[c] !== e_v || obs_b[c] !== e_b || obs_d[c] !== e_d ||
          (e_cs && (obs_c[c] !== e_c || obs_s[c] !== 5'(e_s)))) begin
        n_bad++;
        $display("FAIL ignore_start c=%0d got v%b b%b d%b col%0d step%0d want v%b b%b d%b col%0d step%0d",
                 c, obs_v[c], obs_b[c], obs_d[c], obs_c[c], obs_s[c], e_v, e_b, e_d, e_c, e_s);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] sd;
    int n, ab;
    for (int it = 0; it < 6; it++) begin
      sd = 16'($urandom);
      n  = int'($urandom_range(1, 10));
      ab = ($urandom % 2 == 0) ? int'($urandom_range(2, n * P)) : -1;
      build_colq(sd, n);
      run_seq(sd, n, ab, -1, (ab < 0), n * P + 4);
      for (int c = 0; c <= n * P + 4; c++) begin
        model(c, n, ab);
        n_cmp++;
        if (obs_v[c] !== e_v || obs_b[c] !== e_b || obs_d[c] !== e_d ||
            (e_cs && (obs_c[c] !== e_c || obs_s[c] !== 5'(e_s)))) begin
          n_bad++;
          $display("FAIL random it%0d len%0d ab%0d c=%0d got v%b b%b d%b col%0d step%0d want v%b b%b d%b col%0d step%0d",
                   it, n, ab, c, obs_v[c], obs_b[c], obs_d[c], obs_c[c], obs_s[c], e_v, e_b, e_d, e_c, e_s);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_fixed_seed();
    test_zero_seed();
    test_prefix();
    test_len_zero();
    test_abort_and_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
